hamming_inject_ctrl: RTL and testbench

Self-test sequencer for the Hamming(7,4) error-injection path: encoder -> bit_corrupter -> decoder.
- Sweeps every 4-bit data value against every corrupter index (0 = no corruption, 1..7 = flip that bit).
- Compares the decoder's output to the original data and counts passes and fails.
- Records the first failing vector.
- Sits beside the corrupter and drives its index input; a start/busy/done handshake connects it to the top-level control logic.

---
 rtl/hamming_inject_ctrl_pkg.sv | 25 ++
 rtl/hamming_vec_gen.sv | 50 +++++
 rtl/hamming_inject_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hamming_inject_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_inject_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_inject_ctrl_pkg
// Purpose  : Shared state encodings and sizing constants for the Hamming(7,4)
//            error-injection self-test sequencer.
// Contents : DATA_W, CODE_W, IDX_W, NUM_VECTORS, STATE_W, ST_* encodings
// Revision : 1.0 - initial release
// ============================================================================
package hamming_inject_ctrl_pkg;

    localparam int DATA_W      = 4;
    localparam int CODE_W      = 7;
    localparam int IDX_W       = 3;
    localparam int NUM_VECTORS = 128;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DRIVE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/hamming_vec_gen.sv
`default_nettype none
// ============================================================================
// Module   : hamming_vec_gen
// Purpose  : Test-vector counter pair. The corrupt index is the fast counter
//            (0..7); the data word steps each time the index wraps.
// Ports    : clk       - system clock, rising edge
//            reset_n   - asynchronous active-low reset
//            i_clear   - return both counters to 0 (priority over advance)
//            i_advance - step to the next vector
//            o_data    - current data word
//            o_index   - current corrupt index
//            o_last    - current vector is the final one (15, 7)
// Revision : 1.0 - initial release
// ============================================================================
module hamming_vec_gen
    import hamming_inject_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [DATA_W-1:0] o_data,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_last
);

    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_index;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_index <= '0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_index <= '0;
        end else if (i_advance) begin
            r_index <= r_index + 1'b1;
            if (r_index == '1) begin
                r_data <= r_data + 1'b1;
            end
        end
    end

    assign o_data  = r_data;
    assign o_index = r_index;
    assign o_last  = (r_data == '1) && (r_index == '1);

endmodule
`default_nettype wire

// File: rtl/hamming_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hamming_inject_ctrl
// Purpose  : Self-test sequencer for the encoder -> bit_corrupter -> decoder
//            path. Sweeps all 16 data words against all 8 corrupt indices,
//            scores the decoded result and records the first failure.
// Ports    : clk, reset_n          - clock / asynchronous active-low reset
//            start, abort          - campaign control
//            dec_data              - decoded word returned by the decoder
//            data_out, index_out   - vector driven into encoder / corrupter
//            busy, done            - campaign status (done is a 1-cycle pulse)
//            pass_count/fail_count - per-vector scoreboard
//            fail_valid/fail_data/fail_index - first failing vector
// Config   : `define STOP_ON_FAIL_EN to end the campaign at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_inject_ctrl
    import hamming_inject_ctrl_pkg::*;
#(
    parameter int DEC_LAT = 1,
    parameter int CNT_W   = 8   // must hold NUM_VECTORS
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dec_data,
    output logic [DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]  index_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              fail_valid,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W-1:0]  fail_index
);

    localparam int c_LAT_W     = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
    localparam bit c_SKIP_WAIT = (DEC_LAT == 0);

    logic [STATE_W-1:0] r_state;
    logic [c_LAT_W-1:0] r_lat_cnt;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_pass_count;
    logic [CNT_W-1:0]   r_fail_count;
    logic               r_fail_valid;
    logic [DATA_W-1:0]  r_fail_data;
    logic [IDX_W-1:0]   r_fail_index;

    logic [DATA_W-1:0]  w_data;
    logic [IDX_W-1:0]   w_index;
    logic               w_last;
    logic               w_in_run;
    logic               w_match;
    logic               w_finish;
    logic               w_lat_last;
    logic               w_vec_clear;
    logic               w_vec_adv;

    // Last WAIT cycle: the counter only exists when there is a WAIT phase.
    generate
        if (DEC_LAT == 0) begin : g_no_wait
            assign w_lat_last = 1'b1;
        end else begin : g_wait
            assign w_lat_last = (r_lat_cnt == c_LAT_W'(DEC_LAT - 1));
        end
    endgenerate

    assign w_in_run = (r_state == ST_DRIVE) || (r_state == ST_WAIT) ||
                      (r_state == ST_CHECK);
    assign w_match  = (dec_data == w_data);

`ifdef STOP_ON_FAIL_EN
    assign w_finish = w_last || !w_match;
`else
    assign w_finish = w_last;
`endif

    // An abort parks the vector at (0, 0) so the datapath idles on a known word.
    assign w_vec_clear = ((r_state == ST_IDLE) && start) || (w_in_run && abort);
    assign w_vec_adv   = (r_state == ST_CHECK) && !abort && !w_finish;

    hamming_vec_gen u_vec_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_vec_clear),
        .i_advance (w_vec_adv),
        .o_data    (w_data),
        .o_index   (w_index),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass_count <= '0;
            r_fail_count <= '0;
            r_fail_valid <= 1'b0;
            r_fail_data  <= '0;
            r_fail_index <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // start has priority over a simultaneous abort here.
                    if (start) begin
                        r_pass_count <= '0;
                        r_fail_count <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_data  <= '0;
                        r_fail_index <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (c_SKIP_WAIT) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_lat_cnt <= '0;
                        r_state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_lat_last) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_match) begin
                            r_pass_count <= r_pass_count + 1'b1;
                        end else begin
                            r_fail_count <= r_fail_count + 1'b1;
                            if (!r_fail_valid) begin
                                r_fail_valid <= 1'b1;
                                r_fail_data  <= w_data;
                                r_fail_index <= w_index;
                            end
                        end
                        if (w_finish) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_DRIVE;
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out   = w_data;
    assign index_out  = w_index;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass_count = r_pass_count;
    assign fail_count = r_fail_count;
    assign fail_valid = r_fail_valid;
    assign fail_data  = r_fail_data;
    assign fail_index = r_fail_index;

endmodule
`default_nettype wire

// File: tb/tb_hamming_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_inject_ctrl
// Purpose  : Bench for hamming_inject_ctrl with a behavioural Hamming(7,4)
//            encoder/corrupter/decoder (one register stage) in three flavours:
//            ideal, no correction, and dec_data bit 1 stuck at 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_inject_ctrl;

    localparam int c_LAT   = 1;
    localparam int c_CNT_W = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [3:0]          dec_data;
    logic [3:0]          data_out;
    logic [2:0]          index_out;
    logic                busy;
    logic                done;
    logic [c_CNT_W-1:0]  pass_count;
    logic [c_CNT_W-1:0]  fail_count;
    logic                fail_valid;
    logic [3:0]          fail_data;
    logic [2:0]          fail_index;

    hamming_inject_ctrl #(.DEC_LAT(c_LAT), .CNT_W(c_CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .dec_data   (dec_data),
        .data_out   (data_out),
        .index_out  (index_out),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .fail_valid (fail_valid),
        .fail_data  (fail_data),
        .fail_index (fail_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural datapath ----------------
    int         mode = 0;   // 0 ideal, 1 no correction, 2 bit1 stuck at 1
    logic [3:0] r_dec_q = 4'd0;

    function automatic logic [3:0] path_model(logic [3:0] d, logic [2:0] idx, int m);
        logic [7:1] cw;
        logic [2:0] syn;
        logic [3:0] raw;
        cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
        cw[1] = cw[3] ^ cw[5] ^ cw[7];
        cw[2] = cw[3] ^ cw[6] ^ cw[7];
        cw[4] = cw[5] ^ cw[6] ^ cw[7];
        if (idx != 3'd0) cw[idx] = ~cw[idx];
        raw = {cw[7], cw[6], cw[5], cw[3]};
        syn = {cw[4] ^ cw[5] ^ cw[6] ^ cw[7],
               cw[2] ^ cw[3] ^ cw[6] ^ cw[7],
               cw[1] ^ cw[3] ^ cw[5] ^ cw[7]};
        if (syn != 3'd0) cw[syn] = ~cw[syn];
        case (m)
            1:       return raw;
            2:       return {cw[7], cw[6], cw[5], cw[3]} | 4'b0010;
            default: return {cw[7], cw[6], cw[5], cw[3]};
        endcase
    endfunction

    always @(posedge clk) r_dec_q <= path_model(data_out, index_out, mode);
    assign dec_data = r_dec_q;

    // ---------------- scoreboard ----------------
    typedef struct {
        bit snap;      // 1: compare at next falling edge; 0: compare at done
        int pass_n;
        int fail_n;
        int fv;
        int fd;
        int fi;
        int busy_v;
        bit chk_vec;
        int data_v;
        int idx_v;
        int lat;       // edges from start capture to DONE entry (0 = skip)
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic exp_t mk(bit snap, int p, int f, int fv, int fd, int fi,
                                int b, bit cv, int dv, int iv, int lat);
        exp_t e;
        e.snap = snap; e.pass_n = p; e.fail_n = f; e.fv = fv; e.fd = fd;
        e.fi = fi; e.busy_v = b; e.chk_vec = cv; e.data_v = dv; e.idx_v = iv;
        e.lat = lat;
        return e;
    endfunction

    task automatic chk(string name, int act, int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_rec(exp_t e);
        chk("pass_count", int'(pass_count), e.pass_n);
        chk("fail_count", int'(fail_count), e.fail_n);
        chk("fail_valid", int'(fail_valid), e.fv);
        chk("fail_data",  int'(fail_data),  e.fd);
        chk("fail_index", int'(fail_index), e.fi);
        chk("busy",       int'(busy),       e.busy_v);
        if (e.chk_vec) begin
            chk("data_out",  int'(data_out),  e.data_v);
            chk("index_out", int'(index_out), e.idx_v);
        end
    endtask

    // Monitor: pops expectations as the DUT presents done or a snapshot is due.
    initial begin
        exp_t e;
        bit   prev_done = 1'b0;
        int   wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (prev_done) chk("done_pulse_width", int'(done), 0);
            if (exp_q.size() > 0 && exp_q[0].snap) begin
                e = exp_q.pop_front();
                chk("snap_done", int'(done), 0);
                chk_rec(e);
                wait_cnt = 0;
            end else if (done) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_rec(e);
                    if (e.lat > 0) chk("done_latency", cyc - start_cyc, e.lat);
                end else begin
                    chk("unexpected_done", int'(done), 0);
                end
                wait_cnt = 0;
            end else if (exp_q.size() > 0) begin
                wait_cnt++;
                if (wait_cnt > 2000) begin
                    chk("done_timeout", int'(done), 1);
                    void'(exp_q.pop_front());
                    wait_cnt = 0;
                end
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(int m);
        mode = m;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) begin
            $display("FAIL drain_timeout: queue depth %0d, expected 0", exp_q.size());
            $fatal(1);
        end
    endtask

    initial begin
        // Reset state
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_drain();

        // Ideal path, start re-pulsed mid-run (ignored)
        do_start(0);
        exp_q.push_back(mk(0, 128, 0, 0, 0, 0, 0, 0, 0, 0, 384));
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_drain();

        // abort in IDLE has no effect on held results
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.push_back(mk(1, 128, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        wait_drain();

        // No-correction decoder, start and abort together in IDLE (start wins)
        mode = 1;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        start_cyc = cyc;
`ifdef STOP_ON_FAIL_EN
        exp_q.push_back(mk(0, 3, 1, 1, 0, 3, 0, 1, 0, 3, 12));
`else
        exp_q.push_back(mk(0, 64, 64, 1, 0, 3, 0, 0, 0, 0, 384));
`endif
        wait_drain();

        // Stuck-bit decoder
        do_start(2);
`ifdef STOP_ON_FAIL_EN
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 3));
`else
        exp_q.push_back(mk(0, 64, 64, 1, 0, 0, 0, 0, 0, 0, 384));
`endif
        wait_drain();

        // abort sampled on the 40th edge after start: 13 vectors checked
        do_start(0);
        repeat (39) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.push_back(mk(1, 13, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        wait_drain();
        repeat (20) @(posedge clk);

        // Asynchronous reset mid-run: outputs clear before the next edge
        do_start(1);
        repeat (50) @(posedge clk);
        #2 reset_n = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        wait_drain();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Fresh campaign after abort/reset gives full results
        do_start(0);
        exp_q.push_back(mk(0, 128, 0, 0, 0, 0, 0, 0, 0, 0, 384));
        wait_drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
